// File: rtl/dino_pkg.sv
// Shared types for the T-Rex motion controller: FSM states, sprite pose codes,
// the default ground line and the pose lookup used by the sprite register.
package dino_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DUCK = 3'd2,
    ST_AIR  = 3'd3,
    ST_DEAD = 3'd4
  } dino_state_e;

  localparam logic [3:0] SPR_STAND  = 4'd0;
  localparam logic [3:0] SPR_RUN_A  = 4'd1;
  localparam logic [3:0] SPR_RUN_B  = 4'd2;
  localparam logic [3:0] SPR_DUCK_A = 4'd3;
  localparam logic [3:0] SPR_DUCK_B = 4'd4;
  localparam logic [3:0] SPR_JUMP   = 4'd5;
  localparam logic [3:0] SPR_DEAD   = 4'd6;

  localparam int DINO_GROUND_Y = 360;

  function automatic logic [3:0] dino_pose(input dino_state_e st, input logic leg);
    case (st)
      ST_IDLE: return SPR_STAND;
      ST_RUN:  return leg ? SPR_RUN_B : SPR_RUN_A;
      ST_DUCK: return leg ? SPR_DUCK_B : SPR_DUCK_A;
      ST_AIR:  return SPR_JUMP;
      ST_DEAD: return SPR_DEAD;
      default: return SPR_STAND;
    endcase
  endfunction

endpackage

// File: rtl/dino_vert_integrator.sv
// Vertical kinematics for the dino: velocity/position registers, the landing
// compare and the ceiling and fall-speed clamps. Driven by the motion FSM.
module dino_vert_integrator
  import dino_pkg::*;
#(
  parameter int GROUND_Y   = DINO_GROUND_Y,
  parameter int JUMP_V0    = 20,
  parameter int GRAV       = 1,
  parameter int MAX_FALL_V = 20,
  parameter int Y_W        = 10
) (
  input  logic           AnimateClk,
  input  logic           rst,
  input  logic           i_launch,
  input  logic           i_step,
  input  logic           i_fast,
  output logic [Y_W-1:0] o_dino_y,
  output logic           o_land
);

  localparam int SW = Y_W + 2;
  localparam logic signed [SW-1:0] GROUND_S = SW'(GROUND_Y);
  localparam logic signed [SW-1:0] MAXF_S   = SW'(MAX_FALL_V);
  localparam logic signed [SW-1:0] INC_1    = SW'(GRAV);
  localparam logic signed [SW-1:0] INC_3    = SW'(3 * GRAV);
  localparam logic signed [Y_W:0]  LAUNCH_V = (Y_W + 1)'(-JUMP_V0);

  logic [Y_W-1:0]       r_y;
  logic signed [Y_W:0]  r_vel;
  logic signed [SW-1:0] w_ny;
  logic signed [SW-1:0] w_nv;
  logic signed [SW-1:0] w_inc;
  logic [Y_W-1:0]       w_y_clamp;
  logic signed [Y_W:0]  w_vel_clamp;

  // Candidate next position/velocity with both clamps, evaluated at Y_W+2 bits.
  always_comb begin
    w_inc = i_fast ? INC_3 : INC_1;
    w_ny  = $signed({2'b00, r_y}) + $signed({r_vel[Y_W], r_vel});
    w_nv  = $signed({r_vel[Y_W], r_vel}) + w_inc;
    o_land = (w_ny >= GROUND_S);
    if (w_ny[SW-1]) begin
      w_y_clamp = '0;
    end else begin
      w_y_clamp = w_ny[Y_W-1:0];
    end
    if (w_nv > MAXF_S) begin
      w_vel_clamp = MAXF_S[Y_W:0];
    end else begin
      w_vel_clamp = w_nv[Y_W:0];
    end
  end

  // Position/velocity registers: launch sets takeoff speed, step integrates.
  always_ff @(posedge AnimateClk or posedge rst) begin
    if (rst) begin
      r_y   <= Y_W'(GROUND_Y);
      r_vel <= '0;
    end else if (i_launch) begin
      r_vel <= LAUNCH_V;
    end else if (i_step) begin
      if (o_land) begin
        r_y   <= Y_W'(GROUND_Y);
        r_vel <= '0;
      end else begin
        r_y   <= w_y_clamp;
        r_vel <= w_vel_clamp;
      end
    end
  end

  assign o_dino_y = r_y;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Per-frame T-Rex motion/pose controller. Optional build macro FAST_FALL_EN:
// ducking while airborne triples gravity and shows the DUCK_A pose.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter int GROUND_Y     = DINO_GROUND_Y,
  parameter int JUMP_V0      = 20,
  parameter int GRAV         = 1,
  parameter int MAX_FALL_V   = 20,
  parameter int RUN_ANIM_DIV = 6,
  parameter int Y_W          = 10
) (
  input  logic           AnimateClk,
  input  logic           rst,
  input  logic           enable,
  input  logic           jump,
  input  logic           duck,
  input  logic           hit,
  output logic [Y_W-1:0] dino_y,
  output logic [3:0]     sprite_sel,
  output logic           airborne,
  output logic           ducking,
  output logic           dead
);

  localparam int CNT_W = (RUN_ANIM_DIV > 1) ? $clog2(RUN_ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_ANIM_DIV - 1);

  dino_state_e      r_state;
  dino_state_e      w_state_n;
  logic             r_jump_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             r_leg;
  logic             w_leg_n;
  logic [3:0]       r_sprite;
  logic [3:0]       w_sprite_n;
  logic             r_air;
  logic             r_duck;
  logic             r_dead;
  logic             w_rise;
  logic             w_launch;
  logic             w_step;
  logic             w_land;
  logic             w_fast;

  assign w_rise = jump & ~r_jump_q;

`ifdef FAST_FALL_EN
  assign w_fast = duck;
`else
  assign w_fast = 1'b0;
`endif

  dino_vert_integrator #(
    .GROUND_Y  (GROUND_Y),
    .JUMP_V0   (JUMP_V0),
    .GRAV      (GRAV),
    .MAX_FALL_V(MAX_FALL_V),
    .Y_W       (Y_W)
  ) u_vert (
    .AnimateClk(AnimateClk),
    .rst       (rst),
    .i_launch  (w_launch),
    .i_step    (w_step),
    .i_fast    (w_fast),
    .o_dino_y  (dino_y),
    .o_land    (w_land)
  );

  // Next state plus integrator commands; priority hit > jump edge > duck.
  always_comb begin
    w_state_n = r_state;
    w_launch  = 1'b0;
    w_step    = 1'b0;
    if (enable) begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_n = ST_AIR;
            w_launch  = 1'b1;
          end else begin
            w_state_n = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (hit) begin
            w_state_n = ST_DEAD;
          end else if (w_rise) begin
            w_state_n = ST_AIR;
            w_launch  = 1'b1;
          end else if (duck) begin
            w_state_n = ST_DUCK;
          end else begin
            w_state_n = ST_RUN;
          end
        end
        ST_DUCK: begin
          if (hit) begin
            w_state_n = ST_DEAD;
          end else if (!duck) begin
            w_state_n = ST_RUN;
          end else begin
            w_state_n = ST_DUCK;
          end
        end
        ST_AIR: begin
          if (hit) begin
            w_state_n = ST_DEAD;
          end else begin
            w_step = 1'b1;
            if (w_land) begin
              w_state_n = duck ? ST_DUCK : ST_RUN;
            end else begin
              w_state_n = ST_AIR;
            end
          end
        end
        ST_DEAD: w_state_n = ST_DEAD;
        default: w_state_n = ST_IDLE;
      endcase
    end else begin
      w_state_n = r_state;
    end
  end

  // Leg phase: counter restarts on entering RUN/DUCK, leg flips on wrap.
  always_comb begin
    w_cnt_n = r_cnt;
    w_leg_n = r_leg;
    if ((w_state_n == ST_RUN) || (w_state_n == ST_DUCK)) begin
      if (w_state_n != r_state) begin
        w_cnt_n = '0;
      end else if (r_cnt == CNT_MAX) begin
        w_cnt_n = '0;
        w_leg_n = ~r_leg;
      end else begin
        w_cnt_n = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_n = r_cnt;
    end
    w_sprite_n = dino_pose(w_state_n, w_leg_n);
`ifdef FAST_FALL_EN
    if ((w_state_n == ST_AIR) && duck) begin
      w_sprite_n = SPR_DUCK_A;
    end else begin
      w_sprite_n = dino_pose(w_state_n, w_leg_n);
    end
`endif
  end

  // State, edge detector, animation and registered pose/flag outputs.
  always_ff @(posedge AnimateClk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_jump_q <= 1'b0;
      r_cnt    <= '0;
      r_leg    <= 1'b0;
      r_sprite <= SPR_STAND;
      r_air    <= 1'b0;
      r_duck   <= 1'b0;
      r_dead   <= 1'b0;
    end else if (enable) begin
      r_state  <= w_state_n;
      r_jump_q <= jump;
      r_cnt    <= w_cnt_n;
      r_leg    <= w_leg_n;
      r_sprite <= w_sprite_n;
      r_air    <= (w_state_n == ST_AIR);
      r_duck   <= (w_state_n == ST_DUCK);
      r_dead   <= (w_state_n == ST_DEAD);
    end
  end

  assign sprite_sel = r_sprite;
  assign airborne   = r_air;
  assign ducking    = r_duck;
  assign dead       = r_dead;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Self-checking bench for dino_motion_ctrl (default build): directed test-plan
// steps plus a randomized run, all checked against a behavioural model.
module tb_dino_motion_ctrl;

  logic       AnimateClk;
  logic       rst;
  logic       enable;
  logic       jump;
  logic       duck;
  logic       hit;
  logic [9:0] dino_y;
  logic [3:0] sprite_sel;
  logic       airborne;
  logic       ducking;
  logic       dead;

  int checks = 0;
  int errors = 0;

  // behavioural model: 0 idle, 1 run, 2 duck, 3 air, 4 dead
  int m_mode, m_y, m_v, m_tick, m_leg;
  bit m_jprev;

  dino_motion_ctrl dut (
    .AnimateClk(AnimateClk),
    .rst       (rst),
    .enable    (enable),
    .jump      (jump),
    .duck      (duck),
    .hit       (hit),
    .dino_y    (dino_y),
    .sprite_sel(sprite_sel),
    .airborne  (airborne),
    .ducking   (ducking),
    .dead      (dead)
  );

  initial AnimateClk = 1'b0;
  always #5 AnimateClk = ~AnimateClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_sprite();
    case (m_mode)
      0: return 0;
      1: return 1 + m_leg;
      2: return 3 + m_leg;
      3: return 5;
      default: return 6;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_y = 360; m_v = 0; m_tick = 0; m_leg = 0; m_jprev = 1'b0;
  endtask

  task automatic model_tick(input bit en, input bit j, input bit d, input bit h);
    int old_mode;
    int ny;
    bit rise;
    if (!en) return;
    rise = j && !m_jprev;
    m_jprev = j;
    old_mode = m_mode;
    if (m_mode == 0) begin
      if (rise) begin m_mode = 3; m_v = -20; end
    end else if (m_mode == 1) begin
      if (h) m_mode = 4;
      else if (rise) begin m_mode = 3; m_v = -20; end
      else if (d) m_mode = 2;
    end else if (m_mode == 2) begin
      if (h) m_mode = 4;
      else if (!d) m_mode = 1;
    end else if (m_mode == 3) begin
      if (h) m_mode = 4;
      else begin
        ny = m_y + m_v;
        if (ny >= 360) begin
          m_y = 360; m_v = 0; m_mode = d ? 2 : 1;
        end else begin
          m_y = (ny < 0) ? 0 : ny;
          m_v = (m_v + 1 > 20) ? 20 : m_v + 1;
        end
      end
    end
    if (m_mode == 1 || m_mode == 2) begin
      if (m_mode != old_mode) m_tick = 0;
      else begin
        m_tick++;
        if (m_tick == 6) begin m_tick = 0; m_leg ^= 1; end
      end
    end
  endtask

  task automatic cmp_model();
    chk("dino_y", dino_y, m_y);
    chk("sprite_sel", sprite_sel, exp_sprite());
    chk("airborne", airborne, (m_mode == 3));
    chk("ducking", ducking, (m_mode == 2));
    chk("dead", dead, (m_mode == 4));
  endtask

  task automatic tick(input bit en, input bit j, input bit d, input bit h);
    enable = en; jump = j; duck = d; hit = h;
    @(posedge AnimateClk);
    model_tick(en, j, d, h);
    #1;
    cmp_model();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_y", dino_y, 360);
    chk("arst_spr", sprite_sel, 0);
    chk("arst_flags", {airborne, ducking, dead}, 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [9:0] y_frz;
    rst = 1'b0; enable = 1'b1; jump = 1'b0; duck = 1'b0; hit = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset_y", dino_y, 360);
    chk("reset_spr", sprite_sel, 0);
    chk("reset_flags", {airborne, ducking, dead}, 0);
    @(posedge AnimateClk);
    #1 cmp_model();
    #3 rst = 1'b0;

    // 1: jump from IDLE, full arc
    tick(1, 1, 0, 0);
    chk("takeoff_air", airborne, 1);
    chk("takeoff_y", dino_y, 360);
    for (int k = 1; k <= 41; k++) begin
      tick(1, 0, 0, 0);
      if (k == 1) chk("arc_t1", dino_y, 340);
      if (k == 20) chk("arc_apex", dino_y, 150);
      if (k < 41) chk("arc_air", airborne, 1);
      if (k == 41) begin
        chk("land_y", dino_y, 360);
        chk("land_run_spr", sprite_sel, 1);
      end
    end

    // 2: duck animation in DUCK
    for (int k = 1; k <= 13; k++) begin
      tick(1, 0, 1, 0);
      chk("duck_leg", sprite_sel, (k <= 6 || k == 13) ? 3 : 4);
    end
    tick(1, 0, 0, 0);
    chk("unduck_spr", sprite_sel, 1);

    // 3: edge at apex ignored, held jump at landing ignored, fresh edge launches
    tick(1, 1, 0, 0);
    for (int k = 1; k <= 19; k++) tick(1, 0, 0, 0);
    for (int k = 20; k <= 44; k++) tick(1, 1, 0, 0);
    chk("no_relaunch", airborne, 0);
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    chk("relaunch", airborne, 1);
    for (int k = 1; k <= 41; k++) tick(1, 0, 0, 0);

    // 5: freeze mid-air
    tick(1, 1, 0, 0);
    n = 0;
    for (int k = 1; k <= 10; k++) begin tick(1, 0, 0, 0); n++; end
    y_frz = dino_y;
    for (int k = 1; k <= 10; k++) begin
      tick(0, 1'($urandom), 1'($urandom), 1'($urandom));
      chk("frozen_y", dino_y, y_frz);
      n++;
    end
    while (airborne === 1'b1 && n < 100) begin tick(1, 0, 0, 0); n++; end
    chk("frozen_land_ticks", n, 51);

    // 6: async reset mid-air
    tick(1, 1, 0, 0);
    for (int k = 1; k <= 5; k++) tick(1, 0, 0, 0);
    async_reset();

    // randomized run
    for (int k = 0; k < 600; k++) begin
      tick(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 60) == 0);
      if (m_mode == 4 && ($urandom % 4) == 0) async_reset();
    end

    // 4: hit on the landing tick
    async_reset();
    tick(1, 1, 0, 0);
    for (int k = 1; k <= 40; k++) tick(1, 0, 0, 0);
    tick(1, 0, 0, 1);
    chk("hit_land_y", dino_y, 340);
    chk("hit_land_spr", sprite_sel, 6);
    chk("hit_land_dead", dead, 1);
    chk("hit_land_air", airborne, 0);
    for (int k = 0; k < 8; k++) begin
      tick(1, 1'($urandom), 1'($urandom), 1'($urandom));
      chk("dead_hold_y", dino_y, 340);
      chk("dead_hold_spr", sprite_sel, 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
